cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) between the two result producers: the ALU/branch unit behind the RS and the load/store buffer (LSB).
- Each producer has a small FIFO that absorbs its results. A round-robin arbiter drains one result per cycle onto a registered CDB.
- The CDB is consumed by the ROB, RS and LSB for wakeup and commit.

Parameters:
- ROB_WIDTH, 4, width of ROB tags carried with each result.
- FIFO_DEPTH, 2, entries per producer FIFO; power of two, >= 2.

Ports:
- clk_in  input  1  system clock, rising edge.
- rst_in  input  1  asynchronous, active-low reset.
- rdy_in  input  1  global enable; when 0, all state holds.
- clear  input  1  mispredict flush, synchronous.
- alu_valid  input  1  ALU result present.
- alu_tag  input  ROB_WIDTH  ROB tag of ALU result.
- alu_value  input  32  ALU result value.
- alu_ready  output  1  ALU FIFO can accept this cycle.
- lsb_valid  input  1  LSB result present.
- lsb_tag  input  ROB_WIDTH  ROB tag of LSB result.
- lsb_value  input  32  LSB result value.
- lsb_ready  output  1  LSB FIFO can accept this cycle.
- cdb_valid  output  1  CDB broadcast valid, one cycle per result.
- cdb_tag  output  ROB_WIDTH  broadcast tag.
- cdb_value  output  32  broadcast value.
- cdb_src  output  1  0 = ALU, 1 = LSB.

Behaviour:
- Reset (rst_in = 0, async): both FIFOs empty and pointers 0; cdb_valid, cdb_tag, cdb_value, cdb_src = 0; last_grant = 1 (LSB), so the ALU wins the first tie. alu_ready and lsb_ready = 1 once reset is released.
- Readiness: x_ready = (count_x < FIFO_DEPTH), decoded from registered count only; it never depends on x_valid.
- Push: when rdy_in & x_valid & x_ready & !clear, {tag, value} is written at the write pointer; the write pointer wraps modulo FIFO_DEPTH.
- Arbitration (rdy_in = 1, clear = 0), every cycle:
  - Candidates are the non-empty FIFO heads.
  - With a single candidate, that candidate wins.
  - With both candidates, the requester != last_grant wins.
  - The winner's head is popped and loaded into the CDB registers; cdb_valid = 1 and last_grant = winner.
  - With no candidate, cdb_valid = 0; tag, value and src hold their previous values.
- Push and pop on the same FIFO in the same cycle leave count unchanged.
- A full FIFO that pops this cycle still shows ready = 0 this cycle; no same-cycle refill.
- Latency: a result accepted in cycle N appears on the CDB in cycle N+2 at the earliest (write in N, arbitrate in N+1, registered output).
- Throughput: at most one broadcast per cycle. With both producers streaming, grants strictly alternate, so each producer receives half of the bus.
- clear = 1 (checked only when rdy_in = 1):
  - Next cycle: both FIFOs are empty, cdb_valid = 0 and last_grant = 1.
  - Inputs presented in the clear cycle are dropped.
  - clear overrides arbitration and push.
- rdy_in = 0: no push, no pop, no clear; every register holds, including cdb_valid. Consumers are frozen by the same signal.
- Tag value 0 is legal; the tag is never used as a validity flag.
- Reset asserted mid-operation discards all FIFO contents immediately.

Optional Feature:
- Macro CDB_BYPASS_EN.
- Defined:
  - A result whose FIFO is empty may compete in arbitration in its arrival cycle.
  - The fresh input counts as a candidate under the same round-robin rule.
  - If it wins, it goes straight to the CDB registers without being written, giving latency N+1.
  - If it loses, it is pushed normally.
  - clear still drops it.
- Undefined: arbitration sees only FIFO heads, and latency is N+2 as stated above.

Test Plan:
- Reset, then alu_valid with tag 3 and value 0x0000_0011 in cycle 0 -> cdb_valid = 1 in cycle 2 with tag 3, value 0x11, src 0; in cycle 1 with CDB_BYPASS_EN.
- ALU and LSB both push in the same cycle (tags 1 and 2) -> tag 1 (src 0) in cycle 2, then tag 2 (src 1) in cycle 3. A further dual push (tags 4 and 5) -> LSB goes first only if last_grant = 0.
- LSB pushes on 3 consecutive cycles with FIFO_DEPTH = 2 and the CDB continuously busy with ALU traffic -> lsb_ready = 0 after 2 entries. No entry is lost or duplicated, and broadcast order is the push order.
- Both FIFOs full, then clear asserted for one cycle -> next cycle: cdb_valid = 0, both readies = 1. No stale tag is broadcast afterwards.
- rdy_in held low for 3 cycles while cdb_valid = 1 with tag 7 -> the CDB holds tag 7 valid, and a FIFO pop resumes only once rdy_in returns.
- rst_in pulsed low asynchronously between clock edges with data queued -> outputs go to 0 immediately, and first post-reset pushes behave as after power-on.

Source files
------------

// File: rtl/cdb_arbiter.sv
// CDB arbiter: per-producer result FIFOs drained round-robin onto a registered common data bus.
// Optional macro CDB_BYPASS_EN lets a fresh result arriving at an empty FIFO compete in its arrival cycle.

module cdb_fifo #(
    parameter int ROB_WIDTH  = 4,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  push,
    input  logic                  pop,
    input  logic [ROB_WIDTH+31:0] wdata,
    output logic [ROB_WIDTH+31:0] rdata,
    output logic                  empty,
    output logic                  ready
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    logic [FIFO_DEPTH-1:0][ROB_WIDTH+31:0] mem;
    logic [PW-1:0] wptr, rptr;
    logic [CW-1:0] count;

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + PW'(1);
            if (pop)  rptr <= rptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= wdata;
    end

    assign rdata = mem[rptr];
    assign empty = (count == '0);
    assign ready = (count < FULL);
endmodule

module cdb_arbiter #(
    parameter int ROB_WIDTH  = 4,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 clear,
    input  logic                 alu_valid,
    input  logic [ROB_WIDTH-1:0] alu_tag,
    input  logic [31:0]          alu_value,
    output logic                 alu_ready,
    input  logic                 lsb_valid,
    input  logic [ROB_WIDTH-1:0] lsb_tag,
    input  logic [31:0]          lsb_value,
    output logic                 lsb_ready,
    output logic                 cdb_valid,
    output logic [ROB_WIDTH-1:0] cdb_tag,
    output logic [31:0]          cdb_value,
    output logic                 cdb_src
);
    localparam int EW = ROB_WIDTH + 32;

    // Index 0 is the ALU producer, index 1 the LSB; matches cdb_src encoding.
    logic [1:0][EW-1:0] in_data, head;
    logic [1:0] in_valid, empty, ready, fresh, cand, grant, push, pop;
    logic [EW-1:0] win_data;
    logic win_src, last_grant, go, flush;

    assign in_valid = {lsb_valid, alu_valid};
    assign in_data  = {{lsb_tag, lsb_value}, {alu_tag, alu_value}};
    assign go       = rdy_in & ~clear;
    assign flush    = rdy_in & clear;

    generate
        for (genvar i = 0; i < 2; i++) begin : g_fifo
            cdb_fifo #(.ROB_WIDTH(ROB_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
                .clk   (clk_in),
                .rst_n (rst_in),
                .flush (flush),
                .push  (push[i]),
                .pop   (pop[i]),
                .wdata (in_data[i]),
                .rdata (head[i]),
                .empty (empty[i]),
                .ready (ready[i])
            );
        end
    endgenerate

`ifdef CDB_BYPASS_EN
    // An empty FIFO always has room, so a fresh result there is implicitly accepted.
    assign fresh = in_valid & empty;
`else
    assign fresh = 2'b00;
`endif
    assign cand = ~empty | fresh;

    always_comb begin
        grant = cand;
        if (cand == 2'b11) grant = last_grant ? 2'b01 : 2'b10;
    end

    assign win_src  = grant[1];
    assign win_data = empty[win_src] ? in_data[win_src] : head[win_src];
    assign pop      = {2{go}} & grant & ~empty;
    // A bypassed winner skips the FIFO write.
    assign push     = {2{go}} & in_valid & ready & ~(grant & empty);

    assign alu_ready = ready[0];
    assign lsb_ready = ready[1];

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cdb_valid  <= 1'b0;
            cdb_tag    <= '0;
            cdb_value  <= '0;
            cdb_src    <= 1'b0;
            last_grant <= 1'b1;
        end else if (rdy_in) begin
            if (clear) begin
                cdb_valid  <= 1'b0;
                last_grant <= 1'b1;
            end else if (|grant) begin
                cdb_valid              <= 1'b1;
                {cdb_tag, cdb_value}   <= win_data;
                cdb_src                <= win_src;
                last_grant             <= win_src;
            end else begin
                cdb_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: accepted results queue per producer, popped as the CDB broadcasts.
module tb_cdb_arbiter;
    localparam int RW = 4;

    logic          clk_in = 1'b0, rst_in = 1'b0, rdy_in = 1'b1, clear = 1'b0;
    logic          alu_valid = 1'b0, lsb_valid = 1'b0;
    logic [RW-1:0] alu_tag = '0, lsb_tag = '0;
    logic [31:0]   alu_value = '0, lsb_value = '0;
    logic          alu_ready, lsb_ready, cdb_valid, cdb_src;
    logic [RW-1:0] cdb_tag;
    logic [31:0]   cdb_value;

    typedef struct packed {
        logic [RW-1:0] tag;
        logic [31:0]   val;
    } ent_t;

    ent_t sb_alu[$];
    ent_t sb_lsb[$];
    logic got_src[$];
    int   checks = 0, passes = 0;

    cdb_arbiter #(.ROB_WIDTH(RW), .FIFO_DEPTH(2)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
        .alu_valid(alu_valid), .alu_tag(alu_tag), .alu_value(alu_value), .alu_ready(alu_ready),
        .lsb_valid(lsb_valid), .lsb_tag(lsb_tag), .lsb_value(lsb_value), .lsb_ready(lsb_ready),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value), .cdb_src(cdb_src)
    );

    always #5 clk_in = ~clk_in;

    // One clock of stimulus; accepted inputs go into the scoreboard, a fresh broadcast is popped and compared.
    task automatic step(input logic av, input logic [RW-1:0] at, input logic [31:0] ad,
                        input logic lv, input logic [RW-1:0] lt, input logic [31:0] ld);
        logic live;
        ent_t e;
        alu_valid = av; alu_tag = at; alu_value = ad;
        lsb_valid = lv; lsb_tag = lt; lsb_value = ld;
        live = rdy_in && !clear;
        if (live && av && alu_ready) sb_alu.push_back({at, ad});
        if (live && lv && lsb_ready) sb_lsb.push_back({lt, ld});
        @(posedge clk_in); #1;
        alu_valid = 1'b0; lsb_valid = 1'b0;
        if (live && cdb_valid) begin
            got_src.push_back(cdb_src);
            checks++;
            if ((cdb_src && sb_lsb.size() == 0) || (!cdb_src && sb_alu.size() == 0))
                $display("FAIL unexpected_broadcast: src %0d tag %0d value %h, nothing queued", cdb_src, cdb_tag, cdb_value);
            else begin
                if (cdb_src) e = sb_lsb.pop_front();
                else         e = sb_alu.pop_front();
                if ({cdb_tag, cdb_value} !== e)
                    $display("FAIL cdb_data src%0d: got tag %0d value %h, want tag %0d value %h",
                             cdb_src, cdb_tag, cdb_value, e.tag, e.val);
                else passes++;
            end
        end
    endtask

    task automatic idle();
        step(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic do_reset();
        rst_in = 1'b0;
        sb_alu.delete(); sb_lsb.delete(); got_src.delete();
        #3 rst_in = 1'b1;
        @(posedge clk_in); #1;
    endtask

    task automatic drain(input string name);
        for (int c = 0; c < 16 && (sb_alu.size() + sb_lsb.size()) > 0; c++) idle();
        checks++;
        if (sb_alu.size() + sb_lsb.size() != 0)
            $display("FAIL %s_drain: %0d alu and %0d lsb results never broadcast, want 0", name, sb_alu.size(), sb_lsb.size());
        else passes++;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({cdb_valid, cdb_tag, cdb_value, cdb_src} !== '0)
            $display("FAIL reset_outputs: got valid %b tag %0d value %h src %b, want all 0", cdb_valid, cdb_tag, cdb_value, cdb_src);
        else passes++;
        #1 rst_in = 1'b1;
        @(posedge clk_in); #1;
        checks++;
        if ({alu_ready, lsb_ready, cdb_valid} !== 3'b110)
            $display("FAIL reset_ready: got alu_ready %b lsb_ready %b valid %b, want 1 1 0", alu_ready, lsb_ready, cdb_valid);
        else passes++;
    endtask

    task automatic test_latency(input string name);
        step(1'b1, 4'd3, 32'h11, 1'b0, '0, '0);
`ifndef CDB_BYPASS_EN
        checks++;
        if (cdb_valid !== 1'b0) $display("FAIL %s_early: got valid %b one cycle after push, want 0", name, cdb_valid);
        else passes++;
        idle();
`endif
        checks++;
        if ({cdb_valid, cdb_tag, cdb_value, cdb_src} !== {1'b1, 4'd3, 32'h11, 1'b0})
            $display("FAIL %s: got valid %b tag %0d value %h src %b, want 1 3 00000011 0", name, cdb_valid, cdb_tag, cdb_value, cdb_src);
        else passes++;
    endtask

    task automatic test_dual();
        do_reset();
        step(1'b1, 4'd1, 32'h101, 1'b1, 4'd2, 32'h202);
        drain("dual12");
        checks++;
        if (got_src.size() != 2 || got_src[0] !== 1'b0 || got_src[1] !== 1'b1)
            $display("FAIL dual12_order: got %0d broadcasts first src %b, want 2 with ALU then LSB", got_src.size(), got_src.size() ? got_src[0] : 1'bx);
        else passes++;
        got_src.delete();
        step(1'b1, 4'd4, 32'h404, 1'b1, 4'd5, 32'h505);
        drain("dual45");
        checks++;
        if (got_src.size() != 2 || got_src[0] !== 1'b0)
            $display("FAIL dual45_order: got %0d broadcasts first src %b, want ALU first after LSB grant", got_src.size(), got_src.size() ? got_src[0] : 1'bx);
        else passes++;
        step(1'b1, 4'd6, 32'h606, 1'b0, '0, '0);
        drain("single6");
        got_src.delete();
        step(1'b1, 4'd8, 32'h808, 1'b1, 4'd9, 32'h909);
        drain("dual89");
        checks++;
        if (got_src.size() != 2 || got_src[0] !== 1'b1 || got_src[1] !== 1'b0)
            $display("FAIL dual89_order: got %0d broadcasts first src %b, want LSB first after ALU grant", got_src.size(), got_src.size() ? got_src[0] : 1'bx);
        else passes++;
    endtask

    task automatic test_backpressure();
        int   sent;
        logic lv;
        sent = 0;
        do_reset();
        for (int k = 0; k < 8; k++) begin
`ifndef CDB_BYPASS_EN
            if (k == 2) begin
                checks++;
                if (lsb_ready !== 1'b0) $display("FAIL lsb_full_ready: got %b after two pushes, want 0", lsb_ready);
                else passes++;
            end
`endif
            lv = (sent < 3);
            if (lv && lsb_ready) begin
                step(1'b1, 4'(k), 32'h1000 + k, 1'b1, 4'(10 + sent), 32'h2000 + sent);
                sent++;
            end else
                step(1'b1, 4'(k), 32'h1000 + k, lv, 4'(10 + sent), 32'h2000 + sent);
        end
        checks++;
        if (sent != 3) $display("FAIL lsb_accepted: got %0d, want 3", sent);
        else passes++;
        drain("backpressure");
    endtask

    task automatic test_clear();
        do_reset();
        for (int k = 0; k < 4; k++) step(1'b1, 4'(k), 32'h3000 + k, 1'b1, 4'(8 + k), 32'h4000 + k);
        clear = 1'b1;
        step(1'b1, 4'd14, 32'hdead, 1'b1, 4'd15, 32'hbeef);
        clear = 1'b0;
        checks++;
        if ({cdb_valid, alu_ready, lsb_ready} !== 3'b011)
            $display("FAIL clear_state: got valid %b alu_ready %b lsb_ready %b, want 0 1 1", cdb_valid, alu_ready, lsb_ready);
        else passes++;
        sb_alu.delete(); sb_lsb.delete(); got_src.delete();
        repeat (4) idle();
        checks++;
        if (got_src.size() != 0) $display("FAIL clear_stale: got %0d broadcasts after clear, want 0", got_src.size());
        else passes++;
        step(1'b1, 4'd0, 32'h5a5a, 1'b1, 4'd0, 32'ha5a5);
        drain("post_clear");
        checks++;
        if (got_src.size() != 2 || got_src[0] !== 1'b0)
            $display("FAIL clear_grant: got %0d broadcasts first src %b, want ALU first", got_src.size(), got_src.size() ? got_src[0] : 1'bx);
        else passes++;
    endtask

    task automatic test_rdy();
        do_reset();
        step(1'b1, 4'd7, 32'h77, 1'b1, 4'd8, 32'h88);
        for (int c = 0; c < 4 && !(cdb_valid === 1'b1 && cdb_tag === 4'd7); c++) idle();
        checks++;
        if (cdb_valid !== 1'b1 || cdb_tag !== 4'd7) $display("FAIL rdy_setup: got valid %b tag %0d, want 1 7", cdb_valid, cdb_tag);
        else passes++;
        rdy_in = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step(1'b1, 4'd9, 32'h99, 1'b0, '0, '0);
            checks++;
            if (cdb_valid !== 1'b1 || cdb_tag !== 4'd7)
                $display("FAIL rdy_hold%0d: got valid %b tag %0d, want 1 7", c, cdb_valid, cdb_tag);
            else passes++;
        end
        rdy_in = 1'b1;
        idle();
        checks++;
        if ({cdb_valid, cdb_tag, cdb_src} !== {1'b1, 4'd8, 1'b1})
            $display("FAIL rdy_resume: got valid %b tag %0d src %b, want 1 8 1", cdb_valid, cdb_tag, cdb_src);
        else passes++;
        drain("rdy");
        got_src.delete();
        repeat (3) idle();
        checks++;
        if (got_src.size() != 0) $display("FAIL rdy_no_push: got %0d broadcasts of frozen input, want 0", got_src.size());
        else passes++;
    endtask

    task automatic test_async_reset();
        do_reset();
        step(1'b1, 4'd1, 32'h1, 1'b1, 4'd2, 32'h2);
        step(1'b1, 4'd3, 32'h3, 1'b1, 4'd4, 32'h4);
        #2 rst_in = 1'b0;
        #1;
        checks++;
        if ({cdb_valid, cdb_tag, cdb_value, cdb_src, alu_ready, lsb_ready} !== {1'b0, 4'd0, 32'd0, 1'b0, 1'b1, 1'b1})
            $display("FAIL async_reset: got valid %b tag %0d value %h src %b ready %b%b, want 0 0 0 0 11",
                     cdb_valid, cdb_tag, cdb_value, cdb_src, alu_ready, lsb_ready);
        else passes++;
        sb_alu.delete(); sb_lsb.delete(); got_src.delete();
        #1 rst_in = 1'b1;
        @(posedge clk_in); #1;
        test_latency("post_reset_latency");
        drain("post_reset");
    endtask

    initial begin
        test_reset();
        test_latency("first_latency");
        test_dual();
        test_backpressure();
        test_clear();
        test_rdy();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
